tournament_update_ctrl: RTL and testbench

//  Sequencer for the tournament chooser table (2-bit selector per entry, 00/01 pick pshare, 10/11 pick gshare).
//  - After reset, sweeps the table to 00, one entry per cycle.
//  - Queues in-flight predictions with their operand snapshot.
//  - When branches resolve in order, issues the saturating chooser write and updates the hit/miss counters.
//  - Sits between the fetch-side predictor mux and the chooser table write port.

---
 rtl/tournament_pkg.sv | 14 +
 rtl/tournament_update_ctrl_if.sv | 24 ++
 rtl/tournament_update_ctrl_pred_fifo.sv | 31 +++
 rtl/tournament_update_ctrl.sv | 82 ++++++++
 tb/tb_tournament_update_ctrl.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/tournament_pkg.sv
// tournament_pkg: chooser encodings, sequencer states and the saturating chooser update rule
package tournament_pkg;
  localparam logic [1:0] SEL_SPH = 2'b00;
  localparam logic [1:0] SEL_WPH = 2'b01;
  localparam logic [1:0] SEL_WGH = 2'b10;
  localparam logic [1:0] SEL_SGH = 2'b11;
  typedef enum logic {INIT, RUN} state_t;
  // returns {we, wdata}; only a disagreement between the two predictors trains the chooser
  function automatic logic [2:0] sel_update(input logic [1:0] base, input logic ph, input logic gh, input logic taken);
    return ph == gh ? {1'b0, base} :
           ph == taken ? {1'b1, base == SEL_SPH ? SEL_SPH : base - 2'd1} :
                         {1'b1, base == SEL_SGH ? SEL_SGH : base + 2'd1};
  endfunction
endpackage

// File: rtl/tournament_update_ctrl_if.sv
// tournament_update_ctrl_if: prediction push, resolve, chooser write and status signals of the sequencer
interface tournament_update_ctrl_if #(parameter int N = 32, parameter int SIZE = 10, parameter int DEPTH = 4, parameter int CNT_W = 32);
  logic pred_valid;
  logic [N-1:0] pred_pc;
  logic pred_ph;
  logic pred_gh;
  logic [1:0] pred_sel;
  logic pred_final;
  logic pred_ready;
  logic res_valid;
  logic res_taken;
  logic tbl_we;
  logic [SIZE-1:0] tbl_waddr;
  logic [1:0] tbl_wdata;
  logic init_busy;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic res_err;
  modport master (output pred_valid, pred_pc, pred_ph, pred_gh, pred_sel, pred_final, res_valid, res_taken,
                  input pred_ready, tbl_we, tbl_waddr, tbl_wdata, init_busy, occupancy, hit_count, miss_count, res_err);
  modport slave (input pred_valid, pred_pc, pred_ph, pred_gh, pred_sel, pred_final, res_valid, res_taken,
                 output pred_ready, tbl_we, tbl_waddr, tbl_wdata, init_busy, occupancy, hit_count, miss_count, res_err);
endinterface

// File: rtl/tournament_update_ctrl_pred_fifo.sv
// pred_fifo: in-order queue of outstanding prediction snapshots with wrapping pointers
module pred_fifo #(parameter int W = 37, parameter int DEPTH = 4) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  always_ff @(posedge clock)
    if (push) mem[wp[AW-1:0]] <= din;
  // the extra pointer bit makes occupancy == DEPTH exactly when its MSB is set
  assign occupancy = wp - rp;
  assign full = occupancy[AW];
  assign empty = occupancy == '0;
  assign dout = mem[rp[AW-1:0]];
endmodule

// File: rtl/tournament_update_ctrl.sv
// tournament_update_ctrl: sweeps the chooser table after reset, then trains it from in-order branch resolutions
module tournament_update_ctrl import tournament_pkg::*; #(
  parameter int N = 32,
  parameter int SIZE = 10,
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input logic clock,
  input logic reset,
  tournament_update_ctrl_if.slave bus
);
  localparam int W = N + 5;
  localparam logic [SIZE-1:0] LAST = '1;
  state_t state, state_n;
  logic [SIZE-1:0] idx, idx_n, waddr_n, h_idx;
  logic we_n, push, pop, full, empty, last, upd_we, err_n;
  logic [1:0] wdata_n, base, upd_data;
  logic [CNT_W-1:0] hit_n, miss_n;
  logic [W-1:0] head;
  logic [N-1:0] h_pc;
  logic h_ph, h_gh, h_fin, unused_pc;
  logic [1:0] h_sel;
  pred_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(push), .pop(pop),
    .din({bus.pred_pc, bus.pred_ph, bus.pred_gh, bus.pred_sel, bus.pred_final}),
    .dout(head), .full(full), .empty(empty), .occupancy(bus.occupancy)
  );
  assign {h_pc, h_ph, h_gh, h_sel, h_fin} = head;
  assign h_idx = h_pc[SIZE-1:0];
  assign unused_pc = ^h_pc[N-1:SIZE];
  assign bus.pred_ready = state == RUN && !full;
  assign bus.init_busy = state == INIT;
  assign push = bus.pred_valid && bus.pred_ready;
  assign pop = state == RUN && bus.res_valid && !empty;
  assign last = bus.tbl_we && bus.tbl_waddr == LAST;
  // a write still in flight to the same entry is newer than the snapshot taken at issue
  assign base = bus.tbl_we && bus.tbl_waddr == h_idx ? bus.tbl_wdata : h_sel;
  assign {upd_we, upd_data} = sel_update(base, h_ph, h_gh, bus.res_taken);
  always_comb begin
    state_n = state;
    idx_n = idx;
    we_n = 1'b0;
    waddr_n = bus.tbl_waddr;
    wdata_n = bus.tbl_wdata;
    hit_n = bus.hit_count;
    miss_n = bus.miss_count;
    err_n = bus.res_err || (bus.res_valid && (state == INIT || empty));
    if (state == INIT) begin
      state_n = last ? RUN : INIT;
      we_n = !last;
      waddr_n = last ? bus.tbl_waddr : idx;
      wdata_n = SEL_SPH;
      idx_n = last ? idx : idx + SIZE'(1);
    end else if (pop) begin
      we_n = upd_we;
      waddr_n = h_idx;
      wdata_n = upd_data;
      hit_n = bus.hit_count + CNT_W'(h_fin == bus.res_taken && !(&bus.hit_count));
      miss_n = bus.miss_count + CNT_W'(h_fin != bus.res_taken && !(&bus.miss_count));
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= INIT;
      idx <= '0;
      bus.tbl_we <= 1'b0;
      bus.tbl_waddr <= '0;
      bus.tbl_wdata <= '0;
      bus.hit_count <= '0;
      bus.miss_count <= '0;
      bus.res_err <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      bus.tbl_we <= we_n;
      bus.tbl_waddr <= waddr_n;
      bus.tbl_wdata <= wdata_n;
      bus.hit_count <= hit_n;
      bus.miss_count <= miss_n;
      bus.res_err <= err_n;
    end
endmodule

// File: tb/tb_tournament_update_ctrl.sv
// tb_tournament_update_ctrl: directed steps with a reference queue and expected-write scoreboard
module tb_tournament_update_ctrl;
  typedef struct { logic [31:0] pc; logic ph; logic gh; logic [1:0] sel; logic fin; } ent_t;
  typedef struct { logic we; logic [3:0] addr; logic [1:0] data; } exp_t;
  logic clock, reset;
  int checks = 0, failures = 0;
  int m_hit, m_miss;
  bit m_err, m_lwe;
  logic [3:0] m_la;
  logic [1:0] m_ld;
  ent_t mq[$];
  exp_t sb[$];
  tournament_update_ctrl_if #(.N(32), .SIZE(4), .DEPTH(4), .CNT_W(32)) bus();
  tournament_update_ctrl #(.N(32), .SIZE(4), .DEPTH(4), .CNT_W(32)) dut (.clock(clock), .reset(reset), .bus(bus));
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.pred_valid = 0; bus.pred_pc = '0; bus.pred_ph = 0; bus.pred_gh = 0;
    bus.pred_sel = '0; bus.pred_final = 0; bus.res_valid = 0; bus.res_taken = 0;
  endtask
  task automatic m_reset();
    mq.delete(); sb.delete();
    m_hit = 0; m_miss = 0; m_err = 0; m_lwe = 0; m_la = '0; m_ld = '0;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"}, bus.tbl_we, 0);
    chk({tag, "_waddr"}, bus.tbl_waddr, 0);
    chk({tag, "_wdata"}, bus.tbl_wdata, 0);
    chk({tag, "_ready"}, bus.pred_ready, 0);
    chk({tag, "_busy"}, bus.init_busy, 1);
    chk({tag, "_occ"}, bus.occupancy, 0);
    chk({tag, "_hit"}, bus.hit_count, 0);
    chk({tag, "_miss"}, bus.miss_count, 0);
    chk({tag, "_err"}, bus.res_err, 0);
  endtask
  task automatic sweep(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      chk("sweep_we", bus.tbl_we, 1);
      chk("sweep_waddr", bus.tbl_waddr, k);
      chk("sweep_wdata", bus.tbl_wdata, 0);
      chk("sweep_busy", bus.init_busy, 1);
    end
  endtask
  // one RUN cycle: drive, predict, clock, compare
  task automatic cyc(input bit pv, input logic [31:0] pc, input bit ph, input bit gh, input logic [1:0] sel,
                     input bit fin, input bit rv, input bit rt);
    ent_t e;
    exp_t x;
    logic [1:0] base;
    bit push;
    bus.pred_valid = pv; bus.pred_pc = pc; bus.pred_ph = ph; bus.pred_gh = gh;
    bus.pred_sel = sel; bus.pred_final = fin; bus.res_valid = rv; bus.res_taken = rt;
    #1;
    chk("pred_ready", bus.pred_ready, mq.size() < 4);
    push = pv && mq.size() < 4;
    x.we = 0; x.addr = '0; x.data = '0;
    if (rv && mq.size() == 0) m_err = 1;
    else if (rv) begin
      e = mq.pop_front();
      base = (m_lwe && m_la == e.pc[3:0]) ? m_ld : e.sel;
      if (e.ph != e.gh) begin
        x.we = 1;
        x.addr = e.pc[3:0];
        x.data = (e.gh == rt) ? (base == 2'd3 ? 2'd3 : base + 2'd1) : (base == 2'd0 ? 2'd0 : base - 2'd1);
      end
      if (e.fin == rt) m_hit++; else m_miss++;
    end
    m_lwe = x.we; m_la = x.addr; m_ld = x.data;
    if (push) begin
      e.pc = pc; e.ph = ph; e.gh = gh; e.sel = sel; e.fin = fin;
      mq.push_back(e);
    end
    sb.push_back(x);
    @(posedge clock); #1;
    x = sb.pop_front();
    chk("tbl_we", bus.tbl_we, x.we);
    if (x.we) begin
      chk("tbl_waddr", bus.tbl_waddr, x.addr);
      chk("tbl_wdata", bus.tbl_wdata, x.data);
    end
    chk("occupancy", bus.occupancy, mq.size());
    chk("hit_count", bus.hit_count, m_hit);
    chk("miss_count", bus.miss_count, m_miss);
    chk("res_err", bus.res_err, m_err);
  endtask
  initial begin
    reset = 1; idle(); m_reset();
    #12;
    chk_reset_vals("rst");
    @(negedge clock) reset = 0;
    sweep(16);
    @(posedge clock); #1;
    chk("post_sweep_busy", bus.init_busy, 0);
    chk("post_sweep_ready", bus.pred_ready, 1);
    chk("post_sweep_we", bus.tbl_we, 0);
    // single miss: gshare right -> chooser moves toward gshare
    cyc(1, 32'h5, 1, 0, 2'b01, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    // fill, overflow, pop with blocked push, drain
    cyc(1, 32'h8, 1, 0, 2'b10, 1, 0, 0);
    cyc(1, 32'h9, 0, 1, 2'b00, 0, 0, 0);
    cyc(1, 32'hA, 1, 1, 2'b11, 1, 0, 0);
    cyc(1, 32'hB, 0, 1, 2'b11, 0, 0, 0);
    cyc(1, 32'hC, 1, 0, 2'b01, 1, 0, 0);
    cyc(1, 32'hD, 1, 0, 2'b01, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    // agreement: no write, hit counted; then pshare right at 00 saturates
    cyc(1, 32'h7, 1, 1, 2'b10, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(1, 32'h6, 0, 1, 2'b00, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    // same entry back to back relies on forwarding
    cyc(1, 32'h3, 0, 1, 2'b01, 1, 0, 0);
    cyc(1, 32'h3, 0, 1, 2'b01, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    // resolve while empty, then stickiness
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    idle();
    // async reset in the middle of the sweep
    reset = 1; #1;
    reset = 0; m_reset();
    @(negedge clock);
    sweep(7);
    reset = 1; #1;
    chk_reset_vals("mid_rst");
    @(negedge clock) reset = 0;
    sweep(16);
    @(posedge clock); #1;
    chk("restart_busy", bus.init_busy, 0);
    // resolve during sweep flags an error
    reset = 1; #1;
    @(negedge clock) reset = 0;
    @(posedge clock); #1;
    bus.res_valid = 1;
    @(posedge clock); #1;
    bus.res_valid = 0;
    chk("init_res_err", bus.res_err, 1);
    chk("init_res_waddr", bus.tbl_waddr, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
